// File: rtl/i2s_tx.sv
// I2S transmitter: divides clk down to sck and serialises {left,right} stereo words, with hold/shift double buffering.
// Optional macro I2S_TX_UNDERRUN_CNT_EN adds a saturating 16-bit underrun counter output.
module i2s_tx #(
  parameter int unsigned SCK_DIV  = 4,
  parameter int unsigned SAMPLE_W = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    tx_en,
  input  logic [2*SAMPLE_W-1:0]   sample_in,
  input  logic                    sample_valid,
  output logic                    sample_ready,
  output logic                    sck,
  output logic                    ws,
  output logic                    sd,
  output logic                    underrun,
  output logic                    busy
`ifdef I2S_TX_UNDERRUN_CNT_EN
  ,
  output logic [15:0]             underrun_cnt
`endif
);

  localparam int unsigned FRAME_W = 2 * SAMPLE_W;
  localparam int unsigned DIV_W   = (SCK_DIV > 2) ? $clog2(SCK_DIV) : 1;
  localparam int unsigned BIT_W   = $clog2(FRAME_W);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t             state, state_n;
  logic [DIV_W-1:0]   div_cnt, div_n_c;
  logic [BIT_W-1:0]   bit_cnt, bit_n_c;
  logic [FRAME_W-1:0] hold, shift, load_word_c;
  logic               tick_c, accept_c, hold_full_c, last_bit_c, load_c, underrun_c;

  // tick is the edge on which sck falls (divider wrap)
  assign tick_c      = (div_cnt == DIV_W'(SCK_DIV - 1));
  assign div_n_c     = tick_c ? '0 : div_cnt + DIV_W'(1);
  assign hold_full_c = ~sample_ready;
  assign accept_c    = sample_valid & sample_ready;
  assign last_bit_c  = (bit_cnt == BIT_W'(FRAME_W - 1));
  assign bit_n_c     = last_bit_c ? '0 : bit_cnt + BIT_W'(1);
  // hold wins; otherwise a same-cycle accept bypasses the hold register; otherwise mute
  assign load_word_c = hold_full_c ? hold : (accept_c ? sample_in : '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  // next state, frame load and underrun decision; all only on a tick
  always_comb begin
    state_n    = state;
    load_c     = 1'b0;
    underrun_c = 1'b0;
    if (tick_c) begin
      case (state)
        IDLE: begin
          if (tx_en && (hold_full_c || accept_c)) begin
            state_n = RUN;
            load_c  = 1'b1;
          end
        end
        RUN: begin
          if (last_bit_c) begin
            if (tx_en) begin
              load_c     = 1'b1;
              underrun_c = ~hold_full_c & ~accept_c;
            end else begin
              state_n = DRAIN;
            end
          end
        end
        DRAIN:   state_n = IDLE;
        default: state_n = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_cnt      <= '0;
      sck          <= 1'b0;
      bit_cnt      <= '0;
      hold         <= '0;
      shift        <= '0;
      sample_ready <= 1'b1;
      ws           <= 1'b0;
      sd           <= 1'b0;
      underrun     <= 1'b0;
      busy         <= 1'b0;
    end else begin
      div_cnt  <= div_n_c;
      sck      <= (div_n_c >= DIV_W'(SCK_DIV / 2));
      busy     <= (state_n != IDLE);
      underrun <= underrun_c;

      if (accept_c && !load_c) begin
        hold         <= sample_in;
        sample_ready <= 1'b0;
      end else if (load_c && hold_full_c) begin
        sample_ready <= 1'b1;
      end

      // sd lags shift by one bit, giving the I2S one-sck delay after ws
      if (tick_c) begin
        if (state == RUN) begin
          sd      <= shift[FRAME_W-1];
          bit_cnt <= bit_n_c;
          ws      <= (bit_n_c >= BIT_W'(SAMPLE_W));
          shift   <= load_c ? load_word_c : (shift << 1);
        end else begin
          sd      <= 1'b0;
          bit_cnt <= '0;
          ws      <= 1'b0;
          shift   <= load_c ? load_word_c : '0;
        end
      end
    end
  end

`ifdef I2S_TX_UNDERRUN_CNT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                     underrun_cnt <= '0;
    else if (underrun_c && underrun_cnt != 16'hFFFF) underrun_cnt <= underrun_cnt + 16'd1;
  end
`endif

endmodule

// File: tb/tb_i2s_tx.sv
// Self-checking bench for i2s_tx: table vectors, directed corner sequences and randomized
// streams, all decoded from the sck-rising samples of ws/sd and compared with the words sent.
module tb_i2s_tx;

  localparam int unsigned SCK_DIV  = 4;
  localparam int unsigned SAMPLE_W = 16;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        tx_en = 1'b0;
  logic        sample_valid = 1'b0;
  logic [31:0] sample_in = '0;
  logic        sample_ready, sck, ws, sd, underrun, busy;
`ifdef I2S_TX_UNDERRUN_CNT_EN
  logic [15:0] underrun_cnt;
`endif

  i2s_tx #(.SCK_DIV(SCK_DIV), .SAMPLE_W(SAMPLE_W)) dut (
    .clk          (clk),
    .rst          (rst),
    .tx_en        (tx_en),
    .sample_in    (sample_in),
    .sample_valid (sample_valid),
    .sample_ready (sample_ready),
    .sck          (sck),
    .ws           (ws),
    .sd           (sd),
    .underrun     (underrun),
    .busy         (busy)
`ifdef I2S_TX_UNDERRUN_CNT_EN
    ,
    .underrun_cnt (underrun_cnt)
`endif
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_bad = 0;

  // I2S line as seen by a receiver: one ws/sd sample per sck rising edge while busy
  logic        sd_q[$];
  logic        ws_q[$];
  logic [31:0] exp_q[$];
  logic        sck_prev = 1'b0;
  logic        ur_prev  = 1'b0;
  int          ur_cycles = 0;
  int          ur_pulses = 0;

  always @(negedge clk) begin
    if (sck && !sck_prev && busy) begin
      sd_q.push_back(sd);
      ws_q.push_back(ws);
    end
    if (underrun) begin
      ur_cycles <= ur_cycles + 1;
      if (!ur_prev) ur_pulses <= ur_pulses + 1;
    end
    sck_prev <= sck;
    ur_prev  <= underrun;
  end

  typedef struct {
    logic [31:0] word;
    logic [15:0] left;
    logic [15:0] right;
  } vec_t;

  vec_t vecs[5];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic clear_rec();
    sd_q.delete();
    ws_q.delete();
    exp_q.delete();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tx_en = 1'b0;
    sample_valid = 1'b0;
    sample_in = '0;
    cyc(2);
    rst = 1'b0;
    cyc(1);
  endtask

  // hold valid until a ready edge takes the word
  task automatic send(input logic [31:0] w);
    logic was_rdy;
    int   t;
    t = 0;
    sample_in = w;
    sample_valid = 1'b1;
    do begin
      was_rdy = sample_ready;
      cyc(1);
      t++;
    end while (!was_rdy && t < 400);
    sample_valid = 1'b0;
    chk("send accepted", 32'(was_rdy), 32'd1);
    if (was_rdy) exp_q.push_back(w);
  endtask

  task automatic wait_busy(input int max, output int t);
    t = 0;
    while (!busy && t < max) begin cyc(1); t++; end
    chk("wait busy", 32'(busy), 32'd1);
  endtask

  task automatic wait_idle(input int max);
    int t;
    t = 0;
    while (busy && t < max) begin cyc(1); t++; end
    chk("wait idle", 32'(busy), 32'd0);
  endtask

  // while ready is low, optionally drive junk valids that must be ignored
  task automatic wait_ready(input int max, input bit junk);
    int t;
    t = 0;
    while (!sample_ready && t < max) begin
      sample_valid = junk && ($urandom_range(0, 3) == 0);
      sample_in    = 32'hDEAD_0000 | 32'($urandom_range(0, 16'hFFFF));
      cyc(1);
      t++;
    end
    sample_valid = 1'b0;
    chk("wait ready", 32'(sample_ready), 32'd1);
  endtask

  // stream must be: leading 0, then each expected word MSB first, then one drain bit
  task automatic check_stream(input string name);
    int n, exp_len;
    logic [31:0] w, wv;
    n = exp_q.size();
    exp_len = (n == 0) ? 0 : 32 * n + 1;
    chk({name, " stream len"}, 32'(sd_q.size()), 32'(exp_len));
    if (sd_q.size() == exp_len && n > 0) begin
      chk({name, " lead sd"}, 32'(sd_q[0]), 32'd0);
      for (int k = 0; k < n; k++) begin
        for (int j = 0; j < 32; j++) begin
          w[31-j]  = sd_q[1 + 32*k + j];
          wv[31-j] = ws_q[32*k + j];
        end
        chk({name, " word"}, w, exp_q[k]);
        chk({name, " ws pattern"}, wv, 32'h0000_FFFF);
      end
      chk({name, " drain ws"}, 32'(ws_q[32*n]), 32'd0);
    end
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int t, ub, uc;
    logic [15:0] l, r;
    logic [31:0] wv;
    logic s_prev;

    vecs[0] = '{32'hA5A5_0F0F, 16'hA5A5, 16'h0F0F};
    vecs[1] = '{32'h8000_7FFF, 16'h8000, 16'h7FFF};
    vecs[2] = '{32'h0001_FFFE, 16'h0001, 16'hFFFE};
    vecs[3] = '{32'hFFFF_0000, 16'hFFFF, 16'h0000};
    vecs[4] = '{32'h1234_5678, 16'h1234, 16'h5678};

    // reset state while clocks run
    cyc(3);
    chk("rst sck", 32'(sck), 32'd0);
    chk("rst ws", 32'(ws), 32'd0);
    chk("rst sd", 32'(sd), 32'd0);
    chk("rst ready", 32'(sample_ready), 32'd1);
    chk("rst underrun", 32'(underrun), 32'd0);
    chk("rst busy", 32'(busy), 32'd0);
`ifdef I2S_TX_UNDERRUN_CNT_EN
    chk("rst underrun_cnt", 32'(underrun_cnt), 32'd0);
`endif

    // single-word frames from the table
    for (int i = 0; i < 5; i++) begin
      do_reset();
      clear_rec();
      ub = ur_pulses;
      tx_en = 1'b1;
      send(vecs[i].word);
      wait_busy(20, t);
      tx_en = 1'b0;
      wait_idle(300);
      chk("vec stream len", 32'(sd_q.size()), 32'd33);
      if (sd_q.size() == 33) begin
        for (int j = 0; j < 16; j++) begin
          l[15-j] = sd_q[1 + j];
          r[15-j] = sd_q[17 + j];
        end
        for (int j = 0; j < 32; j++) wv[31-j] = ws_q[j];
        chk("vec left", 32'(l), 32'(vecs[i].left));
        chk("vec right", 32'(r), 32'(vecs[i].right));
        chk("vec ws", wv, 32'h0000_FFFF);
        chk("vec drain ws", 32'(ws_q[32]), 32'd0);
      end
      chk("vec idle ws", 32'(ws), 32'd0);
      chk("vec idle sd", 32'(sd), 32'd0);
      chk("vec idle ready", 32'(sample_ready), 32'd1);
      chk("vec no underrun", 32'(ur_pulses - ub), 32'd0);
    end

    // back-to-back words
    do_reset();
    clear_rec();
    ub = ur_pulses;
    tx_en = 1'b1;
    send(32'h8000_7FFF);
    send(32'h0001_FFFE);
    chk("b2b ready low after accept", 32'(sample_ready), 32'd0);
    wait_ready(300, 1'b0);
    tx_en = 1'b0;
    wait_idle(300);
    check_stream("b2b");
    chk("b2b no underrun", 32'(ur_pulses - ub), 32'd0);

    // underrun: one word then nothing
    do_reset();
    clear_rec();
    ub = ur_pulses;
    uc = ur_cycles;
    tx_en = 1'b1;
    send(32'hC001_D00D);
    t = 0;
    while (ur_pulses == ub && t < 300) begin cyc(1); t++; end
    tx_en = 1'b0;
    wait_idle(300);
    exp_q.push_back(32'h0);
    check_stream("underrun");
    chk("underrun pulses", 32'(ur_pulses - ub), 32'd1);
    chk("underrun width", 32'(ur_cycles - uc), 32'd1);
`ifdef I2S_TX_UNDERRUN_CNT_EN
    chk("underrun_cnt", 32'(underrun_cnt), 32'd1);
`endif

    // stop at bit 5 with a word waiting, then restart
    do_reset();
    clear_rec();
    tx_en = 1'b1;
    send(32'hC3C3_3C3C);
    wait_busy(20, t);
    t = 0;
    while (sd_q.size() < 6 && t < 200) begin cyc(1); t++; end
    tx_en = 1'b0;
    send(32'h5A5A_A5A5);
    void'(exp_q.pop_back());
    wait_idle(300);
    check_stream("stop");
    chk("stop ws", 32'(ws), 32'd0);
    chk("stop hold kept", 32'(sample_ready), 32'd0);
    clear_rec();
    exp_q.push_back(32'h5A5A_A5A5);
    tx_en = 1'b1;
    wait_busy(20, t);
    chk("restart within one sck", 32'(t <= int'(SCK_DIV)), 32'd1);
    tx_en = 1'b0;
    wait_idle(300);
    check_stream("restart");

    // asynchronous reset at bit 20
    do_reset();
    clear_rec();
    tx_en = 1'b1;
    send(32'h7777_1111);
    send(32'h2222_9999);
    t = 0;
    while (sd_q.size() < 21 && t < 300) begin cyc(1); t++; end
    #2 rst = 1'b1;
    #1;
    chk("async rst sck", 32'(sck), 32'd0);
    chk("async rst ws", 32'(ws), 32'd0);
    chk("async rst sd", 32'(sd), 32'd0);
    chk("async rst busy", 32'(busy), 32'd0);
    chk("async rst ready", 32'(sample_ready), 32'd1);
    cyc(2);
    rst = 1'b0;
    clear_rec();
    ub = ur_pulses;
    cyc(300);
    check_stream("post rst");
    chk("post rst busy", 32'(busy), 32'd0);
    chk("post rst underrun", 32'(ur_pulses - ub), 32'd0);
    tx_en = 1'b0;

    // bypass on the IDLE->RUN tick, then a valid while ready is low
    do_reset();
    clear_rec();
    tx_en = 1'b1;
    s_prev = 1'b0;
    t = 0;
    while (!(sck && s_prev) && t < 20) begin
      s_prev = sck;
      cyc(1);
      t++;
    end
    sample_in = 32'hB0B0_0B0B;
    sample_valid = 1'b1;
    cyc(1);
    sample_valid = 1'b0;
    exp_q.push_back(32'hB0B0_0B0B);
    chk("bypass ready stays", 32'(sample_ready), 32'd1);
    chk("bypass busy", 32'(busy), 32'd1);
    send(32'h1357_9BDF);
    chk("ignore ready low", 32'(sample_ready), 32'd0);
    sample_in = 32'hDEAD_BEEF;
    sample_valid = 1'b1;
    cyc(1);
    sample_valid = 1'b0;
    wait_ready(300, 1'b0);
    tx_en = 1'b0;
    wait_idle(300);
    check_stream("bypass");

    // randomized streams with random gaps and ignored junk valids
    for (int round = 0; round < 2; round++) begin
      do_reset();
      clear_rec();
      ub = ur_pulses;
      tx_en = 1'b1;
      for (int k = 0; k < 8; k++) begin
        if (k > 0) wait_ready(300, 1'b1);
        cyc($urandom_range(0, 40));
        send($urandom);
      end
      wait_ready(300, 1'b1);
      cyc($urandom_range(0, 100));
      tx_en = 1'b0;
      wait_idle(400);
      check_stream("random");
      chk("random no underrun", 32'(ur_pulses - ub), 32'd0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
